// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: zero-page control registers, address decode into RAM / boot
// ROM / banked I/O, and per-region CPU wait-state insertion via rdy_o.
// Optional feature macro: MEM_MAP_WAIT_EN (wait_cfg register + wait-state FSM).
module mem_map_ctrl #(
    parameter int unsigned NUM_IO      = 6,
    parameter logic [7:0]  IO_PAGE     = 8'hFE,
    parameter logic [7:0]  ROM_BASE_HI = 8'hE0,
    parameter int unsigned WAIT_W      = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              R_W_n,
    input  logic [15:0]       addr_i,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              rdy_o,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              rom_cs,
    output logic [NUM_IO-1:0] io_cs,
    output logic              addr_dec_cs
);

    logic [7:0]        io_bank_q;
    logic [7:0]        io_bank_h_q;
    logic [7:0]        rom_sel_q;
    logic [7:0]        wait_cfg_rd;
    logic              reg_we;
    logic [NUM_IO-1:0] bank_vec;

    // Control registers are written only on a completed CPU write cycle
    assign reg_we = ~R_W_n & addr_dec_cs & rdy_o;

    // Zero-page control registers 0x0000-0x0002
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            io_bank_q   <= '0;
            io_bank_h_q <= '0;
            rom_sel_q   <= '0;
        end else if (reg_we) begin
            case (addr_i[1:0])
                2'd0:    io_bank_q   <= data_i;
                2'd1:    io_bank_h_q <= data_i;
                2'd2:    rom_sel_q   <= data_i;
                default: ;
            endcase
        end
    end

    // One-hot image of io_bank; all-zero when the bank is out of range
    always_comb begin
        bank_vec = '0;
        for (int unsigned i = 0; i < NUM_IO; i++) begin
            if (io_bank_q == 8'(i)) begin
                bank_vec[i] = 1'b1;
            end
        end
    end

    // Priority address decode: control regs, I/O page, ROM overlay, RAM
    always_comb begin
        addr_dec_cs = 1'b0;
        ram_cs      = 1'b0;
        rom_cs      = 1'b0;
        io_cs       = '0;
        if (addr_i[15:2] == '0) begin
            addr_dec_cs = 1'b1;
        end else if (addr_i[15:8] == IO_PAGE) begin
            if (|bank_vec) begin
                io_cs = bank_vec;
            end else begin
                ram_cs = 1'b1;
            end
        end else if ((addr_i[15:8] >= ROM_BASE_HI) && !rom_sel_q[0]) begin
            rom_cs = 1'b1;
        end else begin
            ram_cs = 1'b1;
        end
    end

    // Control-register read mux
    always_comb begin
        data_o = '0;
        if (addr_dec_cs) begin
            case (addr_i[1:0])
                2'd0:    data_o = io_bank_q;
                2'd1:    data_o = io_bank_h_q;
                2'd2:    data_o = rom_sel_q;
                default: data_o = wait_cfg_rd;
            endcase
        end
    end

`ifdef MEM_MAP_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_e;

    logic [7:0]        wait_cfg_q;
    state_e            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] n_io, n_rom, n_wait;
    logic              rdy_fsm;

    // Wait-state configuration register 0x0003
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wait_cfg_q <= '0;
        end else if (reg_we && (addr_i[1:0] == 2'd3)) begin
            wait_cfg_q <= data_i;
        end
    end

    assign wait_cfg_rd = wait_cfg_q;
    assign n_io        = WAIT_W'(wait_cfg_q);
    assign n_rom       = WAIT_W'(wait_cfg_q >> WAIT_W);

    // Wait count of the region currently addressed
    always_comb begin
        n_wait = '0;
        if (|io_cs) begin
            n_wait = n_io;
        end else if (rom_cs) begin
            n_wait = n_rom;
        end
    end

    // FSM state and stall counter registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE counts as the first stall cycle, WAIT covers the rest
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (n_wait != '0) begin
                    cnt_d   = n_wait - 1'b1;
                    state_d = (n_wait == WAIT_W'(1)) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= WAIT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output: ready except while a slow access is being stretched
    always_comb begin
        rdy_fsm = 1'b1;
        case (state_q)
            ST_IDLE: rdy_fsm = (n_wait == '0);
            ST_WAIT: rdy_fsm = 1'b0;
            ST_DONE: rdy_fsm = 1'b1;
            default: rdy_fsm = 1'b1;
        endcase
    end

    assign rdy_o = ~rst_n_i | rdy_fsm;
`else
    assign wait_cfg_rd = '0;
    assign rdy_o       = 1'b1;
`endif

    assign ram_we = ram_cs & ~R_W_n & rdy_o;

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Self-checking bench for mem_map_ctrl: directed steps plus random accesses
// checked against a register/decode model. Wait-state steps need MEM_MAP_WAIT_EN.
module tb_mem_map_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rdy;
    logic        ram_cs;
    logic        ram_we;
    logic        rom_cs;
    logic [5:0]  io_cs;
    logic        dec_cs;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] m_reg [4];

    always #5 clk = ~clk;

    mem_map_ctrl #(
        .NUM_IO(6),
        .IO_PAGE(8'hFE),
        .ROM_BASE_HI(8'hE0),
        .WAIT_W(4)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .R_W_n(rw_n),
        .addr_i(addr),
        .data_i(din),
        .data_o(dout),
        .rdy_o(rdy),
        .ram_cs(ram_cs),
        .ram_we(ram_we),
        .rom_cs(rom_cs),
        .io_cs(io_cs),
        .addr_dec_cs(dec_cs)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    endtask

    // Reference decode from the memory-map rules
    task automatic model_dec(input logic [15:0] a, output logic e_dec, output logic e_ram,
                             output logic e_rom, output logic [5:0] e_io, output int unsigned n);
        int unsigned hi;
        hi = int'(a) / 256;
        e_dec = 1'b0; e_ram = 1'b0; e_rom = 1'b0; e_io = 6'b0; n = 0;
        if (int'(a) <= 3) e_dec = 1'b1;
        else if (hi == 'hFE) begin
            if (m_reg[0] < 6) e_io = 6'b000001 << m_reg[0];
            else e_ram = 1'b1;
        end else if (hi >= 'hE0 && (m_reg[2] % 2) == 0) e_rom = 1'b1;
        else e_ram = 1'b1;
`ifdef MEM_MAP_WAIT_EN
        if (e_io != 6'b0) n = m_reg[3] % 16;
        else if (e_rom) n = m_reg[3] / 16;
`endif
    endtask

    // One CPU access: expects n stalled cycles then one ready cycle
    task automatic access(input logic [15:0] a, input logic r, input logic [7:0] d);
        logic e_dec, e_ram, e_rom;
        logic [5:0] e_io;
        int unsigned n;
        logic [7:0] e_dout;
        model_dec(a, e_dec, e_ram, e_rom, e_io, n);
        e_dout = e_dec ? m_reg[a[1:0]] : 8'h00;
        addr = a; rw_n = r; din = d;
        for (int cyc = 0; cyc <= int'(n); cyc++) begin
            @(negedge clk);
            chk("dec_cs", 16'(dec_cs), 16'(e_dec));
            chk("ram_cs", 16'(ram_cs), 16'(e_ram));
            chk("rom_cs", 16'(rom_cs), 16'(e_rom));
            chk("io_cs", 16'(io_cs), 16'(e_io));
            chk("data_o", 16'(dout), 16'(e_dout));
            chk("rdy", 16'(rdy), (cyc == int'(n)) ? 16'd1 : 16'd0);
            chk("ram_we", 16'(ram_we), 16'(e_ram & ~r & (cyc == int'(n))));
            @(posedge clk); #1;
        end
        if (e_dec && !r) begin
`ifdef MEM_MAP_WAIT_EN
            m_reg[a[1:0]] = d;
`else
            if (a[1:0] != 2'd3) m_reg[a[1:0]] = d;
`endif
        end
        rw_n = 1'b1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rr;
        rst_n = 1'b0; rw_n = 1'b1; addr = 16'h0000; din = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdy_in_reset", 16'(rdy), 16'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset state and default decode
        for (int i = 0; i < 4; i++) access(16'(i), 1'b1, 8'h00);
        access(16'hFE10, 1'b1, 8'h00);
        access(16'hF000, 1'b1, 8'h00);

        // Bank select, out-of-range bank, ROM overlay disable
        access(16'h0000, 1'b0, 8'h03);
        access(16'hFE20, 1'b1, 8'h00);
        access(16'h0000, 1'b0, 8'h07);
        access(16'hFE20, 1'b1, 8'h00);
        access(16'h0001, 1'b0, 8'hA5);
        access(16'h0001, 1'b1, 8'h00);
        access(16'h0002, 1'b0, 8'h01);
        access(16'hFFFF, 1'b1, 8'h00);
        access(16'hFFFF, 1'b0, 8'h5A);
        access(16'h0002, 1'b0, 8'h00);
        access(16'hFFFF, 1'b0, 8'h5A);
        access(16'hDFFF, 1'b1, 8'h00);
        access(16'hE000, 1'b1, 8'h00);

        // Wait-state register: regions and stall lengths
        access(16'h0000, 1'b0, 8'h00);
        access(16'h0003, 1'b0, 8'h23);
        access(16'h0003, 1'b1, 8'h00);
        access(16'hFE00, 1'b1, 8'h00);
        access(16'hE000, 1'b1, 8'h00);
        access(16'h1234, 1'b0, 8'h11);

`ifdef MEM_MAP_WAIT_EN
        // Reset on the 2nd stalled cycle aborts the stall
        access(16'h0003, 1'b0, 8'h05);
        addr = 16'hFE00; rw_n = 1'b1;
        @(negedge clk);
        chk("stall1", 16'(rdy), 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall2", 16'(rdy), 16'd0);
        rst_n = 1'b0;
        #1;
        chk("rdy_on_reset", 16'(rdy), 16'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) access(16'(i), 1'b1, 8'h00);
        access(16'hFE00, 1'b1, 8'h00);

        // Back-to-back I/O write then RAM write
        access(16'h0003, 1'b0, 8'h02);
        access(16'hFE05, 1'b0, 8'h77);
        access(16'h0200, 1'b0, 8'h88);
`endif

        // Random accesses against the model
        for (int it = 0; it < 80; it++) begin
            rr = 1'($urandom);
            rd = 8'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    ra = 16'($urandom_range(0, 3));
                    if (ra == 16'h0000) rd = 8'($urandom_range(0, 9));
                    rr = 1'b0;
                end
                1: ra = 16'($urandom_range(0, 3));
                2: ra = {8'hFE, 8'($urandom)};
                3: ra = 16'($urandom_range(16'hE000, 16'hFFFF));
                default: ra = 16'($urandom);
            endcase
            access(ra, rr, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_map_ctrl.md
# mem_map_ctrl

Parametrised memory-map controller for the nano6502 CPU bus. It holds the zero-page control registers and decodes each CPU address into RAM, boot ROM, or one of `NUM_IO` banked I/O devices in the I/O page. It also inserts per-region wait states by pulling the CPU `RDY` line low. It sits between the 6502 core and all memory/peripheral chip-select inputs.

## Interface
Parameters:
- `NUM_IO`, default 6: number of I/O bank channels (1..16); `io_cs` width.
- `IO_PAGE`, default 8'hFE: high byte of the 256-byte I/O window.
- `ROM_BASE_HI`, default 8'hE0: high byte of the ROM overlay start; the overlay ends at 0xFFFF inclusive.
- `WAIT_W`, default 4: width of each wait-state field.

Ports:
- `clk_i`  in  1  system clock; all state updates on rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `R_W_n`  in  1  CPU read (1) / write (0).
- `addr_i`  in  16  CPU address.
- `data_i`  in  8  CPU write data.
- `data_o`  out  8  control-register read data; 0 when `addr_dec_cs`=0.
- `rdy_o`  out  1  CPU ready; 0 stalls the CPU with address and data held.
- `ram_cs`  out  1  RAM select.
- `ram_we`  out  1  RAM write strobe.
- `rom_cs`  out  1  ROM select.
- `io_cs`  out  NUM_IO  one-hot I/O device select.
- `addr_dec_cs`  out  1  control-register select (0x0000–0x0003).

## Operation
Control registers (all reset to 0x00):
- 0x0000 `io_bank`: selects the I/O device.
- 0x0001 `io_bank_h`: readable and writable, no decode effect.
- 0x0002 `rom_sel`: bit0=1 disables the ROM overlay; other bits are storage only.
- 0x0003 `wait_cfg`: [WAIT_W-1:0] = I/O wait count `Nio`; [2*WAIT_W-1:WAIT_W] = ROM wait count `Nrom` (only the 8 bits present are used).

Decode priority, combinational from `addr_i` and current registers; exactly one select is high:
1. 0x0000–0x0003 → `addr_dec_cs`.
2. I/O page, `io_bank` < NUM_IO → `io_cs[io_bank]`.
3. I/O page, `io_bank` ≥ NUM_IO → `ram_cs`.
4. `addr_i[15:8]` ≥ ROM_BASE_HI and `rom_sel[0]`=0 → `rom_cs`.
5. Otherwise → `ram_cs`.

Notes:
- Bank 0 is a device like any other (`io_cs[0]`); there is no implicit ROM bank.
- Register writes occur on an edge where `R_W_n`=0, `addr_dec_cs`=1 and `rdy_o`=1.
- `ram_we` = `ram_cs` & ~`R_W_n` & `rdy_o`.

Wait-state FSM (states IDLE, WAIT, DONE). The slow-region wait count `N` is `Nio` when any `io_cs` bit is high, `Nrom` when `rom_cs` is high, and 0 otherwise.
- IDLE, N=0: `rdy_o`=1, stay IDLE.
- IDLE, N>0: `rdy_o`=0 this cycle; load `cnt`=N-1; go to DONE if N=1, else WAIT.
- WAIT: `rdy_o`=0; decrement `cnt`; go to DONE when `cnt` reaches 1.
- DONE: `rdy_o`=1 (the access completes); go to IDLE unconditionally, so the held address cannot retrigger.
- Net effect: every slow access sees exactly N cycles of `rdy_o`=0 followed by one cycle of `rdy_o`=1.

## Timing
- Selects and `data_o` are combinational, zero latency from `addr_i`.
- A register write becomes visible to decode on the cycle after the write edge.
- If `wait_cfg` is written during a stall, the change takes effect from the next access.
- Reset: while `rst_n_i`=0, `rdy_o`=1 and the FSM goes to IDLE. On the edge, all registers and `cnt` clear. Selects follow the reset register values, e.g. 0xFE10 gives `io_cs[0]`.
- Reset during WAIT aborts the stall; the first cycle after reset is IDLE.
- Consecutive slow accesses each incur a full N-cycle stall; the DONE→IDLE transition takes no extra cycle.

## Configuration
- `MEM_MAP_WAIT_EN` defined: `wait_cfg` register and the wait-state FSM are present, as described above.
- `MEM_MAP_WAIT_EN` undefined:
  - `rdy_o` is tied to 1 and no FSM is built.
  - Writes to 0x0003 are ignored; reads of 0x0003 return 0x00, with `addr_dec_cs` still 1.
  - `ram_we` reduces to `ram_cs` & ~`R_W_n`.

## Test plan
- Reset, then read 0x0000–0x0003 → `data_o`=0x00 each, `addr_dec_cs`=1. Read 0xFE10 → `io_cs`=6'b000001. Read 0xF000 → `rom_cs`=1.
- Write 0x0000←0x03, access 0xFE20 → `io_cs`=6'b001000. Write 0x0000←0x07 (NUM_IO=6), access 0xFE20 → `ram_cs`=1, `io_cs`=0.
- Write 0x0002←0x01, access 0xFFFF → `ram_cs`=1; on a write cycle `ram_we`=1. Write 0x0002←0x00, access 0xFFFF → `rom_cs`=1, `ram_we`=0.
- (WAIT_EN) Write 0x0003←0x23, hold 0xFE00 → `rdy_o` low 3 cycles then high 1 cycle. Hold 0xE000 → `rdy_o` low 2 cycles then high 1. Access 0x1234 → `rdy_o` stays 1.
- (WAIT_EN) `Nio`=5, assert `rst_n_i`=0 on the 2nd stalled cycle → `rdy_o`=1 immediately and all registers 0x00 after the edge. Next 0xFE00 access → no stall.
- (WAIT_EN) `Nio`=2, CPU write to 0xFE05 then RAM write to 0x0200 on consecutive accesses → one 2-cycle stall. `ram_we` is high only on the single cycle at 0x0200.
